// File: rtl/vector_issue_controller.sv
// vector_issue_controller
// -----------------------------------------------------------------------------
// Initiator side of the vector function unit (VFU) execute interface.
// It takes one decoded vector arithmetic instruction at a time and drives the
// VFU operand bus with a one-cycle execute strobe. It then follows the VFU
// status until the result arrives. The result is merged with the old
// destination under mask and tail rules and offered to the register file
// writeback port.
//
// Optional feature (compile-time macro VEC_ISSUE_TIMEOUT_EN):
//   When defined, a watchdog counts WAIT cycles. When the count reaches
//   TIMEOUT_CYCLES without a valid FINISHED, the controller drops the
//   instruction, returns to IDLE and raises the sticky err flag.
//   When undefined, WAIT waits indefinitely and err is tied to 0.
//
// Ports:
//   clk, rst              clock; synchronous active-low reset
//   rdy_in                global ready; freezes acceptance and ISSUE when low
//   instr_valid/ready     instruction handshake (ready only in IDLE)
//   instr_*               decoded instruction fields, operands, old vd, v0 mask
//   fu_execute            one-cycle start strobe to the VFU
//   fu_*  (outputs)       registered copies of the instruction fields
//   fu_result, fu_status  VFU result vector and 2-bit status
//   wb_valid/ready        writeback handshake
//   wb_vd, wb_data        writeback destination index and merged vector
//   busy                  high whenever the controller is not IDLE
//   err                   sticky watchdog timeout flag
// -----------------------------------------------------------------------------
module vector_issue_controller #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int TIMEOUT_CYCLES   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_in,

    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [2:0]                    instr_vsew,
    input  logic                          instr_vm,
    input  logic [ENTRY_INDEX_SIZE:0]     instr_vl,
    input  logic [4:0]                    instr_vd,
    input  logic [VECTOR_SIZE*LEN-1:0]    instr_vs1,
    input  logic [VECTOR_SIZE*LEN-1:0]    instr_vs2,
    input  logic [VECTOR_SIZE*LEN-1:0]    instr_vd_old,
    input  logic [VECTOR_SIZE*LEN-1:0]    instr_mask,
    input  logic [LEN-1:0]                instr_imm,
    input  logic [LEN-1:0]                instr_rs,
    input  logic [2:0]                    instr_alu_signal,
    input  logic [1:0]                    instr_operand_type,
    input  logic [4:0]                    instr_ext_type,
    input  logic [5:0]                    instr_funct6,

    output logic                          fu_execute,
    output logic [2:0]                    fu_vsew,
    output logic                          fu_vm,
    output logic [ENTRY_INDEX_SIZE:0]     fu_length,
    output logic [VECTOR_SIZE*LEN-1:0]    fu_vs1,
    output logic [VECTOR_SIZE*LEN-1:0]    fu_vs2,
    output logic [VECTOR_SIZE*LEN-1:0]    fu_mask,
    output logic [LEN-1:0]                fu_imm,
    output logic [LEN-1:0]                fu_rs,
    output logic [2:0]                    fu_alu_signal,
    output logic [1:0]                    fu_operand_type,
    output logic [4:0]                    fu_ext_type,
    output logic [5:0]                    fu_funct6,
    input  logic [VECTOR_SIZE*LEN-1:0]    fu_result,
    input  logic [1:0]                    fu_status,

    output logic                          wb_valid,
    input  logic                          wb_ready,
    output logic [4:0]                    wb_vd,
    output logic [VECTOR_SIZE*LEN-1:0]    wb_data,

    output logic                          busy,
    output logic                          err
);

    localparam int VLEN = VECTOR_SIZE * LEN;

    // VFU status encodings (match defines.v)
    localparam logic [1:0] VEC_ALU_NOP      = 2'd0;
    localparam logic [1:0] VEC_ALU_WORKING  = 2'd1;
    localparam logic [1:0] VEC_ALU_FINISHED = 2'd2;

    // Largest supported element width code (EIGHT_BYTE)
    localparam logic [2:0] EIGHT_BYTE = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_WB
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              seen_working_q;
    logic [VLEN-1:0]   vd_old_q;
    logic [4:0]        vd_q;
    logic [VLEN-1:0]   merged;
    logic              accept;
    logic              issue_fire;
    logic              finish_ok;
    logic              timeout_hit;

    // Handshake and strobe decode. The outputs are gated with rst so that they
    // read 0 for the whole time reset is held.
    assign instr_ready = rst && rdy_in && (state_q == ST_IDLE);
    assign accept      = instr_valid && instr_ready;
    assign issue_fire  = rst && rdy_in && (state_q == ST_ISSUE) &&
                         (fu_status != VEC_ALU_WORKING);
    assign fu_execute  = issue_fire;

    // A FINISHED status counts only after WORKING has been seen for this
    // instruction. Any earlier FINISHED belongs to a previous operation.
    assign finish_ok   = (state_q == ST_WAIT) &&
                         (fu_status == VEC_ALU_FINISHED) && seen_working_q;

    assign wb_valid    = rst && (state_q == ST_WB);
    assign wb_vd       = vd_q;
    assign busy        = (state_q != ST_IDLE);

`ifdef VEC_ISSUE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] timeout_cnt_q;
    logic          err_q;

    // The count is compared against TIMEOUT_CYCLES-1 because the comparison
    // sees the value before this cycle's increment. The instruction is
    // therefore abandoned at the end of the TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_hit = (state_q == ST_WAIT) && !finish_ok &&
                         (timeout_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign err         = err_q;

    // Watchdog counter and sticky error flag. The counter restarts on every
    // transition into WAIT. err is cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timeout_cnt_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (issue_fire) begin
                timeout_cnt_q <= '0;
            end else if (state_q == ST_WAIT) begin
                timeout_cnt_q <= timeout_cnt_q + TW'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. A zero-length instruction is accepted and then
    // dropped, because the VFU would ignore it anyway.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && (instr_vl != '0)) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_fire) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (finish_ok) begin
                    state_d = ST_WB;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Mask/tail merge, evaluated per byte lane. The lane belongs to element
    // (byte >> vsew). Every element index is below VLMAX by construction, so
    // only the vl limit and the mask bit need to be checked. An unsupported
    // vsew code leaves the old destination untouched.
    always_comb begin
        int elem;
        elem   = 0;
        merged = vd_old_q;
        if (fu_vsew <= EIGHT_BYTE) begin
            for (int b = 0; b < VLEN / 8; b++) begin
                elem = b >> fu_vsew[1:0];
                if ((elem < int'(fu_length)) && (fu_vm || fu_mask[elem])) begin
                    merged[b*8 +: 8] = fu_result[b*8 +: 8];
                end
            end
        end
    end

    // Instruction latch, seen_working tracking and result capture. The
    // operand copies stay stable for the whole operation. A reset in the
    // middle of an operation simply discards it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fu_vsew         <= '0;
            fu_vm           <= 1'b0;
            fu_length       <= '0;
            fu_vs1          <= '0;
            fu_vs2          <= '0;
            fu_mask         <= '0;
            fu_imm          <= '0;
            fu_rs           <= '0;
            fu_alu_signal   <= '0;
            fu_operand_type <= '0;
            fu_ext_type     <= '0;
            fu_funct6       <= '0;
            vd_old_q        <= '0;
            vd_q            <= '0;
            wb_data         <= '0;
            seen_working_q  <= 1'b0;
        end else begin
            if (accept) begin
                fu_vsew         <= instr_vsew;
                fu_vm           <= instr_vm;
                fu_length       <= instr_vl;
                fu_vs1          <= instr_vs1;
                fu_vs2          <= instr_vs2;
                fu_mask         <= instr_mask;
                fu_imm          <= instr_imm;
                fu_rs           <= instr_rs;
                fu_alu_signal   <= instr_alu_signal;
                fu_operand_type <= instr_operand_type;
                fu_ext_type     <= instr_ext_type;
                fu_funct6       <= instr_funct6;
                vd_old_q        <= instr_vd_old;
                vd_q            <= instr_vd;
            end
            if (issue_fire) begin
                seen_working_q <= 1'b0;
            end else if ((state_q == ST_WAIT) && (fu_status == VEC_ALU_WORKING)) begin
                seen_working_q <= 1'b1;
            end
            if (finish_ok) begin
                wb_data <= merged;
            end
        end
    end

endmodule

// File: tb/tb_vector_issue_controller.sv
// tb_vector_issue_controller
// -----------------------------------------------------------------------------
// Directed self-checking bench for vector_issue_controller. Each instruction's
// expected writeback is computed by a bit-level merge model when the
// instruction is driven. It is queued and compared when wb_valid appears.
// The bench plays the VFU role by driving fu_status and fu_result directly.
// Inputs are driven and outputs sampled at the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vector_issue_controller;

    localparam int VLEN = 256;
    localparam logic [1:0] NOP      = 2'd0;
    localparam logic [1:0] WORKING  = 2'd1;
    localparam logic [1:0] FINISHED = 2'd2;

    logic            clk;
    logic            rst;
    logic            rdy_in;
    logic            instr_valid;
    logic            instr_ready;
    logic [2:0]      instr_vsew;
    logic            instr_vm;
    logic [3:0]      instr_vl;
    logic [4:0]      instr_vd;
    logic [VLEN-1:0] instr_vs1, instr_vs2, instr_vd_old, instr_mask;
    logic [31:0]     instr_imm, instr_rs;
    logic [2:0]      instr_alu_signal;
    logic [1:0]      instr_operand_type;
    logic [4:0]      instr_ext_type;
    logic [5:0]      instr_funct6;
    logic            fu_execute;
    logic [2:0]      fu_vsew;
    logic            fu_vm;
    logic [3:0]      fu_length;
    logic [VLEN-1:0] fu_vs1, fu_vs2, fu_mask;
    logic [31:0]     fu_imm, fu_rs;
    logic [2:0]      fu_alu_signal;
    logic [1:0]      fu_operand_type;
    logic [4:0]      fu_ext_type;
    logic [5:0]      fu_funct6;
    logic [VLEN-1:0] fu_result;
    logic [1:0]      fu_status;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_vd;
    logic [VLEN-1:0] wb_data;
    logic            busy;
    logic            err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]      vd;
        logic [VLEN-1:0] data;
    } wb_exp_t;

    wb_exp_t         sb[$];
    logic [VLEN-1:0] pending_res;
    logic [VLEN-1:0] res;

    vector_issue_controller #(
        .LEN(32), .VECTOR_SIZE(8), .ENTRY_INDEX_SIZE(3), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_vsew(instr_vsew), .instr_vm(instr_vm), .instr_vl(instr_vl),
        .instr_vd(instr_vd), .instr_vs1(instr_vs1), .instr_vs2(instr_vs2),
        .instr_vd_old(instr_vd_old), .instr_mask(instr_mask),
        .instr_imm(instr_imm), .instr_rs(instr_rs),
        .instr_alu_signal(instr_alu_signal), .instr_operand_type(instr_operand_type),
        .instr_ext_type(instr_ext_type), .instr_funct6(instr_funct6),
        .fu_execute(fu_execute), .fu_vsew(fu_vsew), .fu_vm(fu_vm),
        .fu_length(fu_length), .fu_vs1(fu_vs1), .fu_vs2(fu_vs2),
        .fu_mask(fu_mask), .fu_imm(fu_imm), .fu_rs(fu_rs),
        .fu_alu_signal(fu_alu_signal), .fu_operand_type(fu_operand_type),
        .fu_ext_type(fu_ext_type), .fu_funct6(fu_funct6),
        .fu_result(fu_result), .fu_status(fu_status),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd),
        .wb_data(wb_data), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [VLEN-1:0] rand256();
        logic [VLEN-1:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // Reference merge: decides bit by bit which source applies
    function automatic logic [VLEN-1:0] model_merge(input logic [2:0] vsew, input logic vm,
            input logic [3:0] vl, input logic [VLEN-1:0] mask,
            input logic [VLEN-1:0] r, input logic [VLEN-1:0] old);
        logic [VLEN-1:0] m;
        int ew;
        m = old;
        if (vsew > 3'd3) return old;
        ew = 8 << vsew;
        for (int bp = 0; bp < VLEN; bp++) begin
            int e;
            e = bp / ew;
            if ((e < int'(vl)) && (vm || mask[e])) m[bp] = r[bp];
        end
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [VLEN-1:0] observed,
                               input logic [VLEN-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] vsew, input logic vm, input logic [3:0] vl,
            input logic [4:0] vd, input logic [VLEN-1:0] mask, input logic [VLEN-1:0] old,
            input logic [VLEN-1:0] r, input bit expect_wb);
        wb_exp_t e;
        instr_vsew         = vsew;
        instr_vm           = vm;
        instr_vl           = vl;
        instr_vd           = vd;
        instr_mask         = mask;
        instr_vd_old       = old;
        instr_vs1          = rand256();
        instr_vs2          = rand256();
        instr_imm          = $urandom();
        instr_rs           = $urandom();
        instr_alu_signal   = 3'($urandom_range(0, 7));
        instr_operand_type = 2'($urandom_range(0, 3));
        instr_ext_type     = 5'($urandom_range(0, 31));
        instr_funct6       = 6'($urandom_range(0, 63));
        pending_res        = r;
        if (expect_wb) begin
            e.vd   = vd;
            e.data = model_merge(vsew, vm, vl, mask, r, old);
            sb.push_back(e);
        end
    endtask

    task automatic finishVfu();
        fu_status = FINISHED;
        fu_result = pending_res;
    endtask

    // Waits a bounded number of cycles for wb_valid and compares the result
    // against the scoreboard. It then holds wb_ready low for 'stall' cycles
    // before accepting, and checks the return to IDLE.
    task automatic collectWb(input int stall);
        bit      found;
        wb_exp_t e;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            fu_status = NOP;
            if (wb_valid) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("wb_valid_seen", VLEN'(found), VLEN'(1));
        if (found && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("wb_data", wb_data, e.data);
            checkOutput("wb_vd", VLEN'(wb_vd), VLEN'(e.vd));
            for (int s = 0; s < stall; s++) begin
                wb_ready = 1'b0;
                @(negedge clk);
                checkOutput("wb_hold_valid", VLEN'(wb_valid), VLEN'(1));
                checkOutput("wb_hold_data", wb_data, e.data);
                checkOutput("wb_hold_vd", VLEN'(wb_vd), VLEN'(e.vd));
                checkOutput("wb_hold_no_ready", VLEN'(instr_ready), VLEN'(0));
            end
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            #1;
            checkOutput("wb_done_idle", VLEN'(busy), VLEN'(0));
            checkOutput("wb_done_valid", VLEN'(wb_valid), VLEN'(0));
        end
    endtask

    initial begin
        rst = 1'b0; rdy_in = 1'b1; instr_valid = 1'b1; wb_ready = 1'b0;
        fu_status = NOP; fu_result = '0; pending_res = '0;
        applyStimulus(3'd2, 1'b1, 4'd8, 5'd1, '0, '0, '0, 1'b0);

        // Reset held for two rising edges with an instruction offered
        repeat (2) @(negedge clk);
        checkOutput("rst_instr_ready", VLEN'(instr_ready), VLEN'(0));
        checkOutput("rst_fu_execute", VLEN'(fu_execute), VLEN'(0));
        checkOutput("rst_wb_valid", VLEN'(wb_valid), VLEN'(0));
        checkOutput("rst_busy", VLEN'(busy), VLEN'(0));
        checkOutput("rst_err", VLEN'(err), VLEN'(0));
        checkOutput("rst_wb_data", wb_data, '0);
        rst = 1'b1; instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", VLEN'(instr_ready), VLEN'(1));

        // Unmasked 32-bit add returning 0x11..0x18
        for (int i = 0; i < 8; i++) res[i*32 +: 32] = 32'h11 + 32'(i);
        applyStimulus(3'd2, 1'b1, 4'd8, 5'd7, rand256(), rand256(), res, 1'b1);
        instr_valid = 1'b1;
        #1 checkOutput("accept_ready", VLEN'(instr_ready), VLEN'(1));
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_t1", VLEN'(fu_execute), VLEN'(1));
        checkOutput("fu_length", VLEN'(fu_length), VLEN'(8));
        checkOutput("fu_vs1", fu_vs1, instr_vs1);
        checkOutput("busy_issue", VLEN'(busy), VLEN'(1));
        @(negedge clk);
        fu_status = WORKING;
        checkOutput("exec_once", VLEN'(fu_execute), VLEN'(0));
        @(negedge clk);
        @(negedge clk);
        finishVfu();
        collectWb(0);

        // Masked byte elements with tail, issue held by rdy_in
        applyStimulus(3'd0, 1'b0, 4'd5, 5'd3, 256'h15, {32{8'hAA}}, {32{8'h55}}, 1'b1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0; rdy_in = 1'b0;
        #1 checkOutput("issue_hold_rdy", VLEN'(fu_execute), VLEN'(0));
        @(negedge clk);
        checkOutput("issue_hold_rdy2", VLEN'(fu_execute), VLEN'(0));
        rdy_in = 1'b1;
        #1 checkOutput("issue_release", VLEN'(fu_execute), VLEN'(1));
        @(negedge clk);
        fu_status = WORKING;
        @(negedge clk);
        finishVfu();
        collectWb(0);

        // vl = 0 is dropped; the next instruction is accepted right after
        applyStimulus(3'd2, 1'b1, 4'd0, 5'd9, rand256(), rand256(), rand256(), 1'b0);
        instr_valid = 1'b1;
        @(negedge clk);
        applyStimulus(3'd1, 1'b0, 4'd3, 5'd12, rand256(), rand256(), rand256(), 1'b1);
        #1;
        checkOutput("vl0_busy", VLEN'(busy), VLEN'(0));
        checkOutput("vl0_no_exec", VLEN'(fu_execute), VLEN'(0));
        checkOutput("vl0_ready_next", VLEN'(instr_ready), VLEN'(1));
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_after_vl0", VLEN'(fu_execute), VLEN'(1));
        @(negedge clk);
        fu_status = WORKING;
        @(negedge clk);
        finishVfu();
        collectWb(5);

        // Stale FINISHED in the first WAIT cycle must be ignored
        applyStimulus(3'd3, 1'b0, 4'd3, 5'd20, rand256(), rand256(), rand256(), 1'b1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_stale", VLEN'(fu_execute), VLEN'(1));
        @(negedge clk);
        fu_status = FINISHED; fu_result = '1;
        @(negedge clk);
        fu_status = WORKING;
        checkOutput("stale_ignored", VLEN'(wb_valid), VLEN'(0));
        checkOutput("stale_busy", VLEN'(busy), VLEN'(1));
        @(negedge clk);
        finishVfu();
        collectWb(0);

        // Unsupported vsew code leaves the old destination
        applyStimulus(3'd5, 1'b1, 4'd8, 5'd30, rand256(), rand256(), rand256(), 1'b1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        fu_status = WORKING;
        @(negedge clk);
        finishVfu();
        collectWb(0);

`ifdef VEC_ISSUE_TIMEOUT_EN
        // Watchdog: VFU stuck WORKING for TIMEOUT_CYCLES=4 WAIT cycles
        applyStimulus(3'd2, 1'b1, 4'd4, 5'd4, rand256(), rand256(), rand256(), 1'b0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_timeout", VLEN'(fu_execute), VLEN'(1));
        @(negedge clk);
        fu_status = WORKING;
        repeat (3) @(negedge clk);
        checkOutput("err_before_limit", VLEN'(err), VLEN'(0));
        checkOutput("busy_before_limit", VLEN'(busy), VLEN'(1));
        @(negedge clk);
        fu_status = NOP;
        checkOutput("err_timeout", VLEN'(err), VLEN'(1));
        checkOutput("timeout_idle", VLEN'(busy), VLEN'(0));
        checkOutput("timeout_no_wb", VLEN'(wb_valid), VLEN'(0));
        @(negedge clk);
        checkOutput("err_sticky", VLEN'(err), VLEN'(1));
`else
        // Without the watchdog a long WORKING period simply waits
        applyStimulus(3'd2, 1'b1, 4'd4, 5'd4, rand256(), rand256(), rand256(), 1'b1);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        checkOutput("exec_long", VLEN'(fu_execute), VLEN'(1));
        @(negedge clk);
        fu_status = WORKING;
        repeat (8) @(negedge clk);
        checkOutput("long_err", VLEN'(err), VLEN'(0));
        checkOutput("long_busy", VLEN'(busy), VLEN'(1));
        checkOutput("long_no_wb", VLEN'(wb_valid), VLEN'(0));
        finishVfu();
        collectWb(0);
`endif

        // Reset in the middle of an operation abandons it
        applyStimulus(3'd2, 1'b1, 4'd8, 5'd15, rand256(), rand256(), rand256(), 1'b0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        fu_status = WORKING; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; fu_status = NOP;
        #1;
        checkOutput("midrst_busy", VLEN'(busy), VLEN'(0));
        checkOutput("midrst_wb_valid", VLEN'(wb_valid), VLEN'(0));
        checkOutput("midrst_err", VLEN'(err), VLEN'(0));
        checkOutput("midrst_ready", VLEN'(instr_ready), VLEN'(1));
        checkOutput("sb_empty", VLEN'(sb.size()), VLEN'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
